jericalla_secuenciador: RTL

//  Instruction-issuing end of the Jericalla datapath interface: replaces hand-driven

---
 rtl/jericalla_pkg.sv | 27 ++
 rtl/jericalla_prog_rom.sv | 19 +
 rtl/jericalla_secuenciador.sv | 116 +++++++++++
 3 files changed

// File: rtl/jericalla_pkg.sv
// Shared widths, program-word control codes and sequencer state encoding
// for the Jericalla instruction sequencer.
package jericalla_pkg;

  localparam int INSTR_W = 17;
  localparam int DATA_W  = 32;
  localparam int CTRL_W  = 2;
  localparam int WORD_W  = CTRL_W + INSTR_W;

  localparam logic [CTRL_W-1:0] CTRL_NORMAL = 2'b00;
  localparam logic [CTRL_W-1:0] CTRL_SKIPZ  = 2'b01;
  localparam logic [CTRL_W-1:0] CTRL_HALT   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [CTRL_W-1:0]  ctrl;
    logic [INSTR_W-1:0] instr;
  } prog_word_t;

endpackage

// File: rtl/jericalla_prog_rom.sv
// Synchronous-read program ROM; contents are preloaded into mem_prog from outside.
module jericalla_prog_rom
  import jericalla_pkg::*;
#(
  parameter int PROG_AW = 4
) (
  input  logic               clk,
  input  logic [PROG_AW-1:0] addr,
  output logic [WORD_W-1:0]  data
);

  logic [WORD_W-1:0] mem_prog [2**PROG_AW];

  // NOTE: memory arrays and their read register get no reset; ROM content is not state.
  always_ff @(posedge clk) begin
    data <= mem_prog[addr];
  end

endmodule

// File: rtl/jericalla_secuenciador.sv
// Program-driven sequencer: fetches words, holds each instruction on the Jericalla
// bus for EXEC_CYCLES, captures salida/ZF_J, advances pc with ZF skip, stops on HALT.
module jericalla_secuenciador
  import jericalla_pkg::*;
#(
  parameter int PROG_AW     = 4,
  parameter int EXEC_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DATA_W-1:0]  salida,
  input  logic               ZF_J,
  output logic [INSTR_W-1:0] instruccion,
  output logic               instr_valid,
  output logic [PROG_AW-1:0] pc,
  output logic [DATA_W-1:0]  resultado,
  output logic               zf,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  rom_data;
  prog_word_t         word;
  logic [PROG_AW-1:0] pc_d;
  logic [PROG_AW:0]   pc_next;
  logic [1:0]         step;
  logic               overflow;
  logic               accept, load_issue, capture, finish;
  logic [CNT_W-1:0]   cnt_q;
  logic [CTRL_W-1:0]  ctrl_q;

  // ROM is addressed with the upcoming pc so the word is ready during FETCH.
  jericalla_prog_rom #(.PROG_AW(PROG_AW)) u_rom (
    .clk  (clk),
    .addr (pc_d),
    .data (rom_data)
  );

  assign word = prog_word_t'(rom_data);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_FETCH;
      ST_FETCH:         state_d = (word.ctrl == CTRL_HALT) ? ST_DONE : ST_ISSUE;
      ST_ISSUE:         if (cnt_q == '0) state_d = ST_CAPTURE;
      ST_CAPTURE:       state_d = overflow ? ST_DONE : ST_FETCH;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (ctrl_q)
      CTRL_SKIPZ:  step = ZF_J ? 2'd2 : 2'd1;
      CTRL_NORMAL: step = 2'd1;
      default:     step = 2'd1;
    endcase
    pc_next    = {1'b0, pc} + (PROG_AW+1)'(step);
    overflow   = pc_next[PROG_AW];
    accept     = (state_q inside {ST_IDLE, ST_DONE}) && (state_d == ST_FETCH);
    load_issue = (state_q == ST_FETCH) && (state_d == ST_ISSUE);
    capture    = (state_q == ST_CAPTURE);
    finish     = (state_q != ST_DONE) && (state_d == ST_DONE);
    pc_d       = pc;
    if (accept)                   pc_d = '0;
    else if (capture && !overflow) pc_d = pc_next[PROG_AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instruccion <= '0;
      instr_valid <= 1'b0;
      pc          <= '0;
      resultado   <= '0;
      zf          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cnt_q       <= '0;
      ctrl_q      <= '0;
    end else begin
      pc          <= pc_d;
      instr_valid <= (state_d == ST_ISSUE) || (state_d == ST_CAPTURE);
      if (accept) begin
        busy <= 1'b1;
        done <= 1'b0;
      end
      if (finish) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      if (load_issue) begin
        instruccion <= word.instr;
        ctrl_q      <= word.ctrl;
        cnt_q       <= CNT_W'(EXEC_CYCLES - 1);
      end else if ((state_q == ST_ISSUE) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (capture) begin
        resultado <= salida;
        zf        <= ZF_J;
      end
    end
  end

endmodule
